// File: rtl/display_arbiter.sv
// Fixed-priority arbiter (error > result > entry) for the 4-digit seven-segment display
// with a minimum hold time. Optional error blink is enabled by defining DISP_BLINK_EN.
module display_arbiter #(
  parameter int HOLD_CYCLES  = 50000000,
  parameter int HOLD_W       = 26,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  req,
  input  logic [15:0] entry_bcd,
  input  logic [15:0] result_bcd,
  input  logic [3:0]  err_code,
  output logic [2:0]  grant,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  digit3,
  output logic [7:0]  digit4
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] G_NONE   = 3'b000;
  localparam logic [2:0] G_ENTRY  = 3'b001;
  localparam logic [2:0] G_RESULT = 3'b010;
  localparam logic [2:0] G_ERROR  = 3'b100;

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]       data_q, data_d;
  logic [3:0]        err_q, err_d;
  logic [7:0]        seg_q [4];
  logic [7:0]        seg_d [4];
  logic [2:0]        winner;
  logic              blank_now;

  function automatic logic [2:0] prio(input logic [2:0] r);
    if (r[2])      return G_ERROR;
    else if (r[1]) return G_RESULT;
    else if (r[0]) return G_ENTRY;
    else           return G_NONE;
  endfunction

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  assign winner = prio(req);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (winner != G_NONE) begin
          state_d    = SHOW;
          grant_d    = winner;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      default: begin
        if (req[2] && !grant_q[2]) begin
          // Error preempts any other owner regardless of remaining hold time.
          grant_d    = G_ERROR;
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q == '0) begin
          if (winner == G_NONE) begin
            state_d = IDLE;
            grant_d = G_NONE;
          end else if (winner != grant_q) begin
            grant_d    = winner;
            hold_cnt_d = HOLD_LOAD;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
    endcase
  end

  // The owner's inputs are followed while its request is high; otherwise the
  // last sampled value stays frozen until the hold expires.
  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (grant_d[0] && req[0]) data_d = entry_bcd;
    if (grant_d[1] && req[1]) data_d = result_bcd;
    if (grant_d[2] && req[2]) err_d  = err_code;
  end

`ifdef DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blank_q, blank_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (!grant_d[2] || !grant_q[2]) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blank_d     = ~blank_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign blank_now = blank_d;
`else
  assign blank_now = 1'b0;
`endif

  // Error frame reads "Err<code>" from left to right.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
      logic [7:0] err_glyph;
      if (gi == 0) begin : g_code
        assign err_glyph = hex_glyph(err_d);
      end else if (gi == 3) begin : g_e
        assign err_glyph = 8'h86;
      end else begin : g_r
        assign err_glyph = 8'hAF;
      end
      assign seg_d[gi] = grant_d[2]      ? (blank_now ? 8'hFF : err_glyph) :
                         (|grant_d[1:0]) ? hex_glyph(data_d[gi*4 +: 4]) :
                                           8'hFF;
    end
  endgenerate

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      grant_q    <= G_NONE;
      hold_cnt_q <= '0;
      data_q     <= '0;
      err_q      <= '0;
      for (int i = 0; i < 4; i++) seg_q[i] <= 8'hFF;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      for (int i = 0; i < 4; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign grant  = grant_q;
  assign digit1 = seg_q[0];
  assign digit2 = seg_q[1];
  assign digit3 = seg_q[2];
  assign digit4 = seg_q[3];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with HOLD_CYCLES=4, BLINK_CYCLES=3.
module tb_display_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  req;
  logic [15:0] entry_bcd;
  logic [15:0] result_bcd;
  logic [3:0]  err_code;
  logic [2:0]  grant;
  logic [7:0]  digit1, digit2, digit3, digit4;

  typedef struct {
    int          id;
    logic [2:0]  g;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   nstep = 0;

  localparam logic [31:0] BLANK = 32'hFFFFFFFF;

  display_arbiter #(
    .HOLD_CYCLES (4),
    .HOLD_W      (3),
    .BLINK_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .entry_bcd (entry_bcd),
    .result_bcd(result_bcd),
    .err_code  (err_code),
    .grant     (grant),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .digit4    (digit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic r_rst, input logic [2:0] r, input logic [15:0] e,
                      input logic [15:0] res, input logic [3:0] ec,
                      input logic [2:0] g, input logic [31:0] d);
    exp_t x;
    @(negedge clk);
    rstn       = r_rst;
    req        = r;
    entry_bcd  = e;
    result_bcd = res;
    err_code   = ec;
    x.id = nstep;
    x.g  = g;
    x.d  = d;
    sb.push_back(x);
    nstep++;
  endtask

  task automatic check_now(input string name);
    total++;
    if (grant !== 3'b000 || {digit4, digit3, digit2, digit1} !== BLANK) begin
      bad++;
      $display("FAIL %s: got grant=%b digits=%h, want grant=000 digits=%h",
               name, grant, {digit4, digit3, digit2, digit1}, BLANK);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared just after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        total++;
        if (grant !== x.g || {digit4, digit3, digit2, digit1} !== x.d) begin
          bad++;
          $display("FAIL step%0d: got grant=%b digits=%h, want grant=%b digits=%h",
                   x.id, grant, {digit4, digit3, digit2, digit1}, x.g, x.d);
        end else begin
          $display("step%0d ok: grant=%b digits=%h", x.id, grant,
                   {digit4, digit3, digit2, digit1});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic vis;
    rstn = 1'b1; req = '0; entry_bcd = '0; result_bcd = '0; err_code = '0;

    // Reset and idle
    step(1, 3'b000, 16'h0000, 16'h0000, 4'h0, 3'b000, BLANK);
    step(0, 3'b000, 16'h0000, 16'h0000, 4'h0, 3'b000, BLANK);
    step(0, 3'b000, 16'h0000, 16'h0000, 4'h0, 3'b000, BLANK);
    // Entry grant, then result waits for hold expiry; entry tracked live
    step(0, 3'b001, 16'h1234, 16'h0009, 4'h0, 3'b001, 32'hF9A4B099);
    step(0, 3'b011, 16'h1234, 16'h0009, 4'h0, 3'b001, 32'hF9A4B099);
    step(0, 3'b011, 16'h1235, 16'h0009, 4'h0, 3'b001, 32'hF9A4B092);
    step(0, 3'b011, 16'h1235, 16'h0009, 4'h0, 3'b001, 32'hF9A4B092);
    step(0, 3'b011, 16'h1235, 16'h0009, 4'h0, 3'b010, 32'hC0C0C090);
    // Error preempts result mid-hold; code frozen once req[2] drops
    step(0, 3'b111, 16'h1235, 16'h0009, 4'h3, 3'b100, 32'h86AFAFB0);
    step(0, 3'b111, 16'h1235, 16'h0009, 4'h3, 3'b100, 32'h86AFAFB0);
    step(0, 3'b000, 16'h1235, 16'h0009, 4'h5, 3'b100, 32'h86AFAFB0);
    step(0, 3'b000, 16'h1235, 16'h0009, 4'h5, 3'b100, 32'h86AFAFB0);
    step(0, 3'b000, 16'h1235, 16'h0009, 4'h5, 3'b000, BLANK);
    // Entry drops req early: frozen value until expiry, then idle
    step(0, 3'b001, 16'h0005, 16'h0009, 4'h0, 3'b001, 32'hC0C0C092);
    step(0, 3'b000, 16'h0777, 16'h0009, 4'h0, 3'b001, 32'hC0C0C092);
    step(0, 3'b000, 16'h0777, 16'h0009, 4'h0, 3'b001, 32'hC0C0C092);
    step(0, 3'b000, 16'h0777, 16'h0009, 4'h0, 3'b001, 32'hC0C0C092);
    step(0, 3'b000, 16'h0777, 16'h0009, 4'h0, 3'b000, BLANK);
    // Same winner at expiry keeps ownership without reload
    step(0, 3'b001, 16'h0001, 16'h0009, 4'h0, 3'b001, 32'hC0C0C0F9);
    step(0, 3'b001, 16'h0001, 16'h0009, 4'h0, 3'b001, 32'hC0C0C0F9);
    step(0, 3'b001, 16'h0001, 16'h0009, 4'h0, 3'b001, 32'hC0C0C0F9);
    step(0, 3'b001, 16'h0001, 16'h0009, 4'h0, 3'b001, 32'hC0C0C0F9);
    step(0, 3'b001, 16'h0001, 16'h0009, 4'h0, 3'b001, 32'hC0C0C0F9);
    step(0, 3'b011, 16'h0001, 16'h0009, 4'h0, 3'b010, 32'hC0C0C090);
    // Asynchronous reset mid-display
    step(1, 3'b011, 16'h0001, 16'h0009, 4'h0, 3'b000, BLANK);
    #1 check_now("async_reset_display");
    // Simultaneous error+result from idle: error wins, result waits
    step(0, 3'b110, 16'h0001, 16'h0009, 4'hA, 3'b100, 32'h86AFAF88);
    step(0, 3'b010, 16'h0001, 16'h0009, 4'hB, 3'b100, 32'h86AFAF88);
    step(0, 3'b010, 16'h0001, 16'h0009, 4'hB, 3'b100, 32'h86AFAF88);
    step(0, 3'b010, 16'h0001, 16'h0009, 4'hB, 3'b100, 32'h86AFAF88);
    step(0, 3'b010, 16'h0001, 16'h0009, 4'hB, 3'b010, 32'hC0C0C090);
    // Steady error: blinks every 3 cycles when blink is built in
    for (int k = 0; k < 8; k++) begin
`ifdef DISP_BLINK_EN
      vis = ((k / 3) % 2) == 0;
`else
      vis = 1'b1;
`endif
      step(0, 3'b100, 16'h0001, 16'h0009, 4'h3, 3'b100, vis ? 32'h86AFAFB0 : BLANK);
    end
    step(1, 3'b100, 16'h0001, 16'h0009, 4'h3, 3'b000, BLANK);
    #1 check_now("async_reset_error");
    step(0, 3'b000, 16'h0001, 16'h0009, 4'h3, 3'b000, BLANK);

    @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
